// File: rtl/picomips_pkg.sv
// ---------------------------------------------------------------------------
// picomips_pkg
// Shared constants for the picoMIPS datapath.
//   FLAG_V/N/Z/C : bit positions of the flags inside the 4-bit {V,N,Z,C} word
//   ZERO_REG     : index of the hardwired-zero register R0
//   PM_DATA_W    : default datapath width (ALU operand width)
// ---------------------------------------------------------------------------
package picomips_pkg;

    localparam int FLAG_V    = 3;
    localparam int FLAG_N    = 2;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_C    = 0;

    localparam int ZERO_REG  = 0;

    localparam int PM_DATA_W = 8;

endpackage : picomips_pkg

// File: rtl/en_reg.sv
// ---------------------------------------------------------------------------
// en_reg
// W-bit register with load enable and asynchronous active-high reset.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  asynchronous active-high reset, clears q to 0
//   en    in  1  load enable
//   d     in  W  data in
//   q     out W  registered data
// ---------------------------------------------------------------------------
module en_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_q <= '0;
        else if (en)
            r_q <= d;
    end

    assign q = r_q;

endmodule : en_reg

// File: rtl/regfile_wb.sv
// ---------------------------------------------------------------------------
// regfile_wb
// Register file and write-back stage of the picoMIPS datapath. Supplies the
// two ALU operands combinationally and captures the ALU result, the ALU
// flags and the LED output on the rising clock edge.
// Ports:
//   clk      in  1   system clock, rising edge
//   reset    in  1   asynchronous active-high reset
//   ra_a     in  AW  read address A
//   ra_b     in  AW  read address B
//   rd_a     out n   read data A (ALU a_in)
//   rd_b     out n   read data B (ALU b_in)
//   we       in  1   register write enable
//   wa       in  AW  write address
//   wd       in  n   write data (ALU result)
//   flags_we in  1   flags register write enable
//   flags_in in  4   ALU flags {V,N,Z,C}
//   flags    out 4   registered flags {V,N,Z,C}
//   out_we   in  1   LED register write enable
//   leds     out n   registered LED output, loaded from wd
// ---------------------------------------------------------------------------
module regfile_wb
    import picomips_pkg::*;
#(
    parameter int n      = PM_DATA_W,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG),
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    output logic [n-1:0]  rd_a,
    output logic [n-1:0]  rd_b,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [n-1:0]  wd,
    input  logic          flags_we,
    input  logic [3:0]    flags_in,
    output logic [3:0]    flags,
    input  logic          out_we,
    output logic [n-1:0]  leds
);

    // Stored register values; entry 0 is a constant zero, not storage.
    logic [n-1:0] w_regs [NREG];

    // A write is only effective for R1..R(NREG-1).
    logic w_wr_valid;
    assign w_wr_valid = we && (wa != AW'(ZERO_REG));

    assign w_regs[0] = '0;

    for (genvar k = 1; k < NREG; k++) begin : g_reg
        logic w_en;
        assign w_en = w_wr_valid && (wa == AW'(k));

        en_reg #(.W(n)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (w_en),
            .d     (wd),
            .q     (w_regs[k])
        );
    end

    en_reg #(.W(4)) u_flags (
        .clk   (clk),
        .reset (reset),
        .en    (flags_we),
        .d     (flags_in),
        .q     (flags)
    );

    en_reg #(.W(n)) u_leds (
        .clk   (clk),
        .reset (reset),
        .en    (out_we),
        .d     (wd),
        .q     (leds)
    );

    // Combinational read with optional forwarding of the in-flight write.
    // w_wr_valid already excludes R0, so R0 can never be forwarded.
    always_comb begin
        rd_a = w_regs[ra_a];
        rd_b = w_regs[ra_b];
        if (BYPASS && w_wr_valid && (ra_a == wa))
            rd_a = wd;
        if (BYPASS && w_wr_valid && (ra_b == wa))
            rd_b = wd;
    end

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ra_a, ra_b, wa;
    logic       we, flags_we, out_we;
    logic [7:0] wd;
    logic [3:0] flags_in;

    logic [7:0] bp_rd_a, bp_rd_b, bp_leds;
    logic [3:0] bp_flags;
    logic [7:0] nb_rd_a, nb_rd_b, nb_leds;
    logic [3:0] nb_flags;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    regfile_wb #(.n(8), .NREG(8), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .reset(reset), .ra_a(ra_a), .ra_b(ra_b),
        .rd_a(bp_rd_a), .rd_b(bp_rd_b), .we(we), .wa(wa), .wd(wd),
        .flags_we(flags_we), .flags_in(flags_in), .flags(bp_flags),
        .out_we(out_we), .leds(bp_leds)
    );

    regfile_wb #(.n(8), .NREG(8), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .ra_a(ra_a), .ra_b(ra_b),
        .rd_a(nb_rd_a), .rd_b(nb_rd_b), .we(we), .wa(wa), .wd(wd),
        .flags_we(flags_we), .flags_in(flags_in), .flags(nb_flags),
        .out_we(out_we), .leds(nb_leds)
    );

    task automatic push(input string tag, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [7:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%02h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ra_a = 3'd1; ra_b = 3'd1; wa = 3'd0; we = 1'b0;
        wd = 8'h00; flags_we = 1'b0; flags_in = 4'h0; out_we = 1'b0;
        tick(); tick();

        // Reset state
        push("rst_rd_a", 8'h00);  chk(bp_rd_a);
        push("rst_flags", 8'h00); chk({4'h0, bp_flags});
        push("rst_leds", 8'h00);  chk(bp_leds);
        reset = 1'b0;

        // 1: populate R3/flags/leds, then asynchronous reset mid-cycle
        we = 1'b1; wa = 3'd3; wd = 8'h5A; flags_we = 1'b1; flags_in = 4'hF; out_we = 1'b1;
        tick();
        we = 1'b0; flags_we = 1'b0; out_we = 1'b0; ra_a = 3'd3;
        #1;
        push("t1_r3_written", 8'h5A); chk(bp_rd_a);
        push("t1_flags_written", 8'h0F); chk({4'h0, bp_flags});
        push("t1_leds_written", 8'h5A); chk(bp_leds);
        #2;
        we = 1'b1; wa = 3'd3; wd = 8'h77;   // write attempted while reset is high
        reset = 1'b1;
        #1;
        push("t1_async_rd_a", 8'h00); chk(nb_rd_a);
        push("t1_async_flags", 8'h00); chk({4'h0, bp_flags});
        push("t1_async_leds", 8'h00); chk(bp_leds);
        tick();
        reset = 1'b0; we = 1'b0;
        #1;
        push("t1_write_in_reset_dropped", 8'h00); chk(bp_rd_a);

        // 2: basic write then read on both ports
        we = 1'b1; wa = 3'd2; wd = 8'hC3;
        tick();
        we = 1'b0; ra_a = 3'd2; ra_b = 3'd2;
        #1;
        push("t2_rd_a", 8'hC3); chk(nb_rd_a);
        push("t2_rd_b", 8'hC3); chk(nb_rd_b);
        we = 1'b1; wa = 3'd5; wd = 8'h11;
        tick();
        we = 1'b0; ra_b = 3'd5;
        #1;
        push("t2_r2_kept", 8'hC3); chk(bp_rd_a);
        push("t2_r5", 8'h11); chk(bp_rd_b);

        // 3: R0 is hardwired zero, no bypass from a write to R0
        we = 1'b1; wa = 3'd0; wd = 8'hFF; ra_a = 3'd0;
        #1;
        push("t3_r0_same_cycle", 8'h00); chk(bp_rd_a);
        tick();
        we = 1'b0;
        #1;
        push("t3_r0_after_edge", 8'h00); chk(bp_rd_a);
        push("t3_r0_after_edge_nb", 8'h00); chk(nb_rd_a);

        // 4: bypass vs stored-value read
        we = 1'b1; wa = 3'd4; wd = 8'h10;
        tick();
        wd = 8'h7E; ra_a = 3'd4; ra_b = 3'd4;
        #1;
        push("t4_bp_rd_a", 8'h7E); chk(bp_rd_a);
        push("t4_bp_rd_b", 8'h7E); chk(bp_rd_b);
        push("t4_nb_rd_a_old", 8'h10); chk(nb_rd_a);
        push("t4_nb_rd_b_old", 8'h10); chk(nb_rd_b);
        tick();
        we = 1'b0;
        #1;
        push("t4_nb_rd_a_new", 8'h7E); chk(nb_rd_a);
        // bypass on port B only
        we = 1'b1; wa = 3'd2; wd = 8'h99; ra_a = 3'd4; ra_b = 3'd2;
        #1;
        push("t4_bp_a_stored", 8'h7E); chk(bp_rd_a);
        push("t4_bp_b_fwd", 8'h99); chk(bp_rd_b);
        push("t4_nb_b_old", 8'hC3); chk(nb_rd_b);
        tick();
        we = 1'b0;

        // 5: flags hold while flags_we is low
        flags_we = 1'b1; flags_in = 4'b1010;
        tick();
        flags_we = 1'b0; flags_in = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            push($sformatf("t5_flags_hold%0d", i), 8'h0A); chk({4'h0, bp_flags});
            tick();
        end

        // 6: register, LEDs and flags written in the same cycle
        we = 1'b1; wa = 3'd7; wd = 8'h3C; out_we = 1'b1; flags_we = 1'b1; flags_in = 4'b0001;
        tick();
        we = 1'b0; out_we = 1'b0; flags_we = 1'b0; wd = 8'hAA; ra_a = 3'd7;
        #1;
        push("t6_r7", 8'h3C); chk(bp_rd_a);
        push("t6_leds", 8'h3C); chk(bp_leds);
        push("t6_flags", 8'h01); chk({4'h0, bp_flags});
        push("t6_leds_nb", 8'h3C); chk(nb_leds);
        tick();
        push("t6_leds_hold", 8'h3C); chk(bp_leds);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_wb
